// File: rtl/sa_ctrl_pkg.sv
// sa_ctrl_pkg: shared types and constants for the sa3x3 sequencer.
//   state_t    - controller state encoding
//   N          - array dimension (rows, columns, lanes)
//   FEED_BEATS - number of skewed feed beats per job (2*N-1)
//   elem_base  - bit offset of element [r][c] in a packed 3x3 matrix
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    localparam int N          = 3;
    localparam int FEED_BEATS = 5;

    // Row-major packing: element [r][c] lives at dw*(N*r+c).
    function automatic int elem_base(input int dw, input int r, input int c);
        return dw * (N * r + c);
    endfunction

endpackage

// File: rtl/sa_skew_mux.sv
// sa_skew_mux: picks the element one lane launches on beat k of the
// diagonally skewed feed. Lane LANE carries row LANE of a matrix and
// starts LANE beats late, so it emits element (k - LANE) while that index
// is 0..N-1 and zero otherwise.
// Ports:
//   k    - beat index (values past the last beat yield zero)
//   row  - the N packed elements of this lane's row, element c at DW*c
//   elem - selected element or zero
module sa_skew_mux
    import sa_ctrl_pkg::*;
#(
    parameter int DW   = 8,
    parameter int LANE = 0
) (
    input  logic [2:0]      k,
    input  logic [N*DW-1:0] row,
    output logic [DW-1:0]   elem
);

    localparam logic [2:0] LANE_K = 3'(LANE);

    logic [2:0] col;

    always_comb begin
        elem = '0;
        col  = k - LANE_K;
        // Before the lane's start beat the subtraction wraps, so gate on k.
        if (k >= LANE_K) begin
            case (col)
                3'd0:    elem = row[0 +: DW];
                3'd1:    elem = row[DW +: DW];
                3'd2:    elem = row[2*DW +: DW];
                default: elem = '0;
            endcase
        end
    end

endmodule

// File: rtl/sa3x3_seq_ctrl.sv
// sa3x3_seq_ctrl: job sequencer for the 3x3 systolic MAC array.
// Accepts one data window and one weight kernel per job, clears the array,
// feeds both matrices as diagonally skewed lane streams, waits for the
// array pipeline to drain and captures the array output as the result.
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   start / ready     - job request handshake (ready only in IDLE)
//   a_mat, w_mat      - 3x3 data / weight, element [r][c] at DW*(3r+c)
//   sa_clear          - one-cycle clear pulse to the array
//   sa_din0..2        - skewed data lanes
//   sa_win0..2        - skewed weight lanes
//   sa_out            - array output
//   result            - captured result, held after the handshake
//   result_valid      - result handshake valid, result_ready - accept
//   busy              - high whenever not IDLE
// All outputs come straight from registers.
module sa3x3_seq_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int DW           = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            ready,
    input  logic [9*DW-1:0] a_mat,
    input  logic [9*DW-1:0] w_mat,
    output logic            sa_clear,
    output logic [DW-1:0]   sa_din0,
    output logic [DW-1:0]   sa_din1,
    output logic [DW-1:0]   sa_din2,
    output logic [DW-1:0]   sa_win0,
    output logic [DW-1:0]   sa_win1,
    output logic [DW-1:0]   sa_win2,
    input  logic [DW-1:0]   sa_out,
    output logic [DW-1:0]   result,
    output logic            result_valid,
    input  logic            result_ready,
    output logic            busy
);

    localparam logic [2:0] LAST_BEAT = 3'(FEED_BEATS - 1);
    localparam logic [3:0] DRAIN_END = 4'(DRAIN_CYCLES);

    state_t            state_reg;
    logic [2:0]        k_reg;
    logic [3:0]        drain_reg;
    logic [9*DW-1:0]   a_reg;
    logic [9*DW-1:0]   w_reg;
    logic              ready_reg;
    logic              busy_reg;
    logic              sa_clear_reg;
    logic [DW-1:0]     result_reg;
    logic              result_valid_reg;
    logic [DW-1:0]     din_reg  [N];
    logic [DW-1:0]     win_reg  [N];
    logic [DW-1:0]     din_next [N];
    logic [DW-1:0]     win_next [N];
    logic [2:0]        sel_k;

    // Lanes are registered, so the mux looks one beat ahead: beat 0 is
    // selected while in CLEAR, beat k_reg+1 while beat k_reg is on the wire.
    assign sel_k = (state_reg == CLEAR) ? 3'd0 : k_reg + 3'd1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            sa_skew_mux #(.DW(DW), .LANE(gi)) u_din_mux (
                .k    (sel_k),
                .row  (a_reg[elem_base(DW, gi, 0) +: N*DW]),
                .elem (din_next[gi])
            );
            sa_skew_mux #(.DW(DW), .LANE(gi)) u_win_mux (
                .k    (sel_k),
                .row  (w_reg[elem_base(DW, gi, 0) +: N*DW]),
                .elem (win_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            k_reg            <= '0;
            drain_reg        <= '0;
            a_reg            <= '0;
            w_reg            <= '0;
            ready_reg        <= 1'b1;
            busy_reg         <= 1'b0;
            sa_clear_reg     <= 1'b0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            for (int r = 0; r < N; r++) begin
                din_reg[r] <= '0;
                win_reg[r] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && ready_reg) begin
                        a_reg        <= a_mat;
                        w_reg        <= w_mat;
                        k_reg        <= '0;
                        ready_reg    <= 1'b0;
                        busy_reg     <= 1'b1;
                        sa_clear_reg <= 1'b1;
                        state_reg    <= CLEAR;
                        for (int r = 0; r < N; r++) begin
                            din_reg[r] <= '0;
                            win_reg[r] <= '0;
                        end
                    end
                end
                CLEAR: begin
                    sa_clear_reg <= 1'b0;
                    k_reg        <= '0;
                    state_reg    <= FEED;
                    for (int r = 0; r < N; r++) begin
                        din_reg[r] <= din_next[r];
                        win_reg[r] <= win_next[r];
                    end
                end
                FEED: begin
                    if (k_reg == LAST_BEAT) begin
                        drain_reg <= '0;
                        state_reg <= DRAIN;
                        for (int r = 0; r < N; r++) begin
                            din_reg[r] <= '0;
                            win_reg[r] <= '0;
                        end
                    end else begin
                        k_reg <= k_reg + 3'd1;
                        for (int r = 0; r < N; r++) begin
                            din_reg[r] <= din_next[r];
                            win_reg[r] <= win_next[r];
                        end
                    end
                end
                DRAIN: begin
                    // The first zero cycle lets the last beat enter the
                    // array; the following DRAIN_CYCLES cover its pipeline.
                    if (drain_reg == DRAIN_END) begin
                        result_reg       <= sa_out;
                        result_valid_reg <= 1'b1;
                        state_reg        <= DONE;
                    end else begin
                        drain_reg <= drain_reg + 4'd1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid_reg <= 1'b0;
                        ready_reg        <= 1'b1;
                        busy_reg         <= 1'b0;
                        state_reg        <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready        = ready_reg;
    assign busy         = busy_reg;
    assign sa_clear     = sa_clear_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign sa_din0      = din_reg[0];
    assign sa_din1      = din_reg[1];
    assign sa_din2      = din_reg[2];
    assign sa_win0      = win_reg[0];
    assign sa_win1      = win_reg[1];
    assign sa_win2      = win_reg[2];

endmodule
